// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: core configuration and CDB packet types shared by the arbiter and its picker.
// Holds slot count, FU count, reorder-tag width, the broadcast packet type and a modular-add helper.
package cdb_arbiter_pkg;
  localparam int CDB_SIZE = 2;
  localparam int FU_NUM = 4;
  localparam int ROB_W = 5;
  typedef struct packed {
    logic valid;
    logic [ROB_W-1:0] reorder;
    logic [31:0] value;
  } cdb_slot_t;
  typedef cdb_slot_t [CDB_SIZE-1:0] cdb_packet_t;
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_arbiter_rr_picker: rotating find-first over a request vector.
// Ports: req_i requests, ptr_i start index; gnt_o one-hot grant, idx_o its index, any_o a grant exists.
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  // Scan from farthest to nearest so the request closest to ptr_i is the last (winning) write.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_add(int'(ptr_i), k, N)]) begin
        gnt_o = N'(1) << wrap_add(int'(ptr_i), k, N);
        idx_o = PW'(wrap_add(int'(ptr_i), k, N));
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to CDB_SIZE FU writeback ports per cycle in rotating priority onto the CDB.
// Ports: clk, rst (async, active-high), flush; fu_valid/fu_reorder/fu_value per FU in;
// fu_ready grant per FU out; cdb_packet registered broadcast of CDB_SIZE slots.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FU_N = FU_NUM,
  parameter int PW = $clog2(FU_N)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [FU_N-1:0]             fu_valid,
  input  logic [FU_N-1:0][ROB_W-1:0]  fu_reorder,
  input  logic [FU_N-1:0][31:0]       fu_value,
  output logic [FU_N-1:0]             fu_ready,
  output cdb_packet_t                 cdb_packet
);
  logic [PW-1:0] ptr_q, ptr_d;
  cdb_packet_t pkt_d;
  logic [CDB_SIZE:0][FU_N-1:0] req;
  logic [CDB_SIZE-1:0][FU_N-1:0] gnt;
  logic [CDB_SIZE-1:0][PW-1:0] idx;
  logic [CDB_SIZE-1:0] any;
  // Each picker sees only the requests not already taken by an earlier slot.
  assign req[0] = (flush || rst) ? '0 : fu_valid;
  for (genvar s = 0; s < CDB_SIZE; s++) begin : g_slot
    cdb_arbiter_rr_picker #(.N(FU_N), .PW(PW)) u_pick (
      .req_i(req[s]),
      .ptr_i(ptr_q),
      .gnt_o(gnt[s]),
      .idx_o(idx[s]),
      .any_o(any[s])
    );
    assign req[s+1] = req[s] & ~gnt[s];
  end
  assign fu_ready = req[0] & ~req[CDB_SIZE];
  // Slots fill from 0 upward, so the highest active slot holds the last granted index.
  always_comb begin
    ptr_d = ptr_q;
    pkt_d = '0;
    for (int s = 0; s < CDB_SIZE; s++) begin
      pkt_d[s].valid = any[s];
      pkt_d[s].reorder = any[s] ? fu_reorder[idx[s]] : '0;
      pkt_d[s].value = any[s] ? fu_value[idx[s]] : '0;
      ptr_d = any[s] ? PW'(wrap_add(int'(idx[s]), 1, FU_N)) : ptr_d;
    end
    ptr_d = flush ? '0 : ptr_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cdb_packet <= '0;
    end else begin
      ptr_q <= ptr_d;
      cdb_packet <= pkt_d;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed check of cdb_arbiter against a queue-free behavioural model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [3:0] fu_valid = '0;
  logic [3:0][ROB_W-1:0] fu_reorder = '0;
  logic [3:0][31:0] fu_value = '0;
  logic [3:0] fu_ready;
  cdb_packet_t cdb_packet;
  int n_chk = 0;
  int n_fail = 0;
  int prob = 0;
  int exp_ptr = 0;
  bit chk_age = 1'b0;
  logic pv [4];
  logic [ROB_W-1:0] pr [4];
  logic [31:0] pw [4];
  int age [4];
  logic [37:0] exp_pkt [2];
  cdb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .fu_valid(fu_valid),
    .fu_reorder(fu_reorder),
    .fu_value(fu_value),
    .fu_ready(fu_ready),
    .cdb_packet(cdb_packet)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [ROB_W-1:0] tag, input logic [31:0] val);
    pv[i] = 1'b1;
    pr[i] = tag;
    pw[i] = val;
    age[i] = 0;
  endtask
  task automatic check_pkt();
    for (int s = 0; s < 2; s++) begin
      logic [37:0] a;
      a = cdb_packet[s];
      check($sformatf("slot%0d", s), 64'(a), 64'(exp_pkt[s]));
    end
  endtask
  // One arbitration cycle: the model scans from its pointer and takes the first two
  // presented requests, which then must appear in the packet after the next edge.
  task automatic cycle(input logic fl);
    logic [3:0] g;
    int cnt;
    int last;
    logic [37:0] nxt [2];
    @(negedge clk);
    check_pkt();
    for (int i = 0; i < 4; i++)
      if (!pv[i] && $urandom_range(99) < prob) set_req(i, ROB_W'($urandom), $urandom);
    for (int i = 0; i < 4; i++) begin
      fu_valid[i] = pv[i];
      fu_reorder[i] = pr[i];
      fu_value[i] = pw[i];
    end
    flush = fl;
    #1;
    g = '0;
    cnt = 0;
    last = -1;
    nxt[0] = '0;
    nxt[1] = '0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (exp_ptr + k) % 4;
      if (!fl && pv[j] && cnt < 2) begin
        g[j] = 1'b1;
        nxt[cnt] = {1'b1, pr[j], pw[j]};
        cnt++;
        last = j;
      end
    end
    check("ready", 64'(fu_ready), 64'(g));
    for (int i = 0; i < 4; i++) begin
      if (pv[i] && !fl) age[i]++;
      if (g[i]) begin
        if (chk_age) check($sformatf("wait_fu%0d", i), 64'(age[i] <= 2), 64'(1));
        pv[i] = 1'b0;
      end
    end
    exp_pkt = nxt;
    exp_ptr = fl ? 0 : (last >= 0 ? (last + 1) % 4 : exp_ptr);
    @(posedge clk);
  endtask
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(fu_ready), 64'(0));
    exp_pkt[0] = '0;
    exp_pkt[1] = '0;
    exp_ptr = 0;
    check_pkt();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pr[i] = '0;
      pw[i] = '0;
      age[i] = 0;
    end
    exp_pkt[0] = '0;
    exp_pkt[1] = '0;
    fu_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("init_ready", 64'(fu_ready), 64'(0));
    check_pkt();
    fu_valid = '0;
    #1 rst = 1'b0;
    prob = 100;
    repeat (4) cycle(1'b0);
    prob = 0;
    repeat (2) cycle(1'b0);
    set_req(2, 5'd5, 32'hDEADBEEF);
    repeat (2) cycle(1'b0);
    set_req(3, 5'd9, 32'h3333_0003);
    set_req(0, 5'd7, 32'h0000_0A0A);
    repeat (2) cycle(1'b0);
    for (int i = 0; i < 4; i++) set_req(i, ROB_W'(i + 16), 32'h1000 + i);
    repeat (3) cycle(1'b0);
    set_req(1, 5'd11, 32'h1111_1111);
    set_req(2, 5'd12, 32'h2222_2222);
    cycle(1'b1);
    repeat (3) cycle(1'b0);
    prob = 100;
    cycle(1'b0);
    reset_mid();
    repeat (3) cycle(1'b0);
    prob = 60;
    for (int i = 0; i < 4; i++) age[i] = 0;
    chk_age = 1'b1;
    repeat (10000) cycle(1'b0);
    prob = 0;
    repeat (3) cycle(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
